// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS fetch-path constants and the fetch entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
    localparam logic [1:0]  EXC_NONE  = 2'b00;
    localparam logic [1:0]  EXC_ADDR  = 2'b10;
    localparam logic [1:0]  EXC_FETCH = 2'b01;
    localparam logic [31:0] NOP_INST  = 32'h0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  exc;
    } fetch_entry_t;

    // A faulting fetch must never reach decode as a real instruction.
    function automatic fetch_entry_t make_entry(input logic [31:0] inst,
                                                input logic [31:0] pc,
                                                input logic [1:0]  exc);
        fetch_entry_t e;
        e.inst = (exc != EXC_NONE) ? NOP_INST : inst;
        e.pc   = pc;
        e.exc  = exc;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fq_storage.sv
`default_nettype none
// ============================================================================
// Module      : fq_storage
// Description : Entry array for the IF/ID queue; falling-edge write,
//               asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module fq_storage
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  fetch_entry_t    wr_data,
    input  logic [AW-1:0]   rd_addr,
    output fetch_entry_t    rd_data
);

    // Contents are don't-care after reset, so the array carries no reset.
    fetch_entry_t r_mem [DEPTH];

    always_ff @(negedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_queue
// Description : IF->ID decoupling FIFO with redirect flush and optional
//               delay-slot preservation. Optional macro QUEUE_BYPASS_EN
//               enables a zero-latency empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_queue
    import mips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          flush_keep,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_inst,
    input  logic [31:0]   in_pc,
    input  logic [1:0]    in_exc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc,
    output logic [1:0]    out_exc,
    output logic [AW:0]   count
);

    localparam logic [AW:0] c_ptr_one = (AW+1)'(1);
    localparam logic [AW:0] c_full    = (AW+1)'(DEPTH);

    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  w_count;
    logic         w_empty;
    logic         w_full;
    logic         w_bypass;
    logic         w_push;
    logic         w_pop;
    logic         w_wr_store;
    logic         w_pop_store;
    fetch_entry_t w_in_entry;
    fetch_entry_t w_head;

    // Wrap-bit pointers: occupancy is simply their difference.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == c_full);
    assign count    = w_count;

    assign in_ready = ~w_full & ~flush;
    assign w_push   = in_valid & in_ready;

`ifdef QUEUE_BYPASS_EN
    assign w_bypass = w_empty & out_ready & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid   = ~w_empty | w_bypass;
    assign w_pop       = out_valid & out_ready;
    assign w_wr_store  = w_push & ~w_bypass;
    assign w_pop_store = w_pop & ~w_empty;

    assign w_in_entry = make_entry(in_inst, in_pc, in_exc);

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .wr_en   (w_wr_store),
        .wr_addr (r_wr_ptr[AW-1:0]),
        .wr_data (w_in_entry),
        .rd_addr (r_rd_ptr[AW-1:0]),
        .rd_data (w_head)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            if (flush_keep && !w_empty) begin
                // Keep only the head (delay slot) unless ID takes it now.
                r_wr_ptr <= r_rd_ptr + c_ptr_one;
                if (w_pop_store) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
            end else begin
                r_rd_ptr <= r_wr_ptr;
            end
        end else begin
            if (w_wr_store) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_store) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Idle outputs are forced to zero rather than exposing stale storage.
    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        out_exc  = EXC_NONE;
        if (w_bypass) begin
            out_inst = w_in_entry.inst;
            out_pc   = w_in_entry.pc;
            out_exc  = w_in_entry.exc;
        end else if (!w_empty) begin
            out_inst = w_head.inst;
            out_pc   = w_head.pc;
            out_exc  = w_head.exc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fetch_queue
// Description : Directed plus random checks of if_id_fetch_queue against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b1;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        flush_keep = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [1:0]  in_exc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  out_exc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    fetch_entry_t q[$];

    if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .flush_keep (flush_keep),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_exc     (in_exc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_exc    (out_exc),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        fetch_entry_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        chk("m_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("m_count", 64'(count), 64'(q.size()));
        chk("m_ready", 64'(in_ready), 64'(q.size() != DEPTH && !flush));
        chk("m_inst", 64'(out_inst), 64'(h.inst));
        chk("m_pc", 64'(out_pc), 64'(h.pc));
        chk("m_exc", 64'(out_exc), 64'(h.exc));
    endtask

    task automatic model_edge();
        bit pop, push;
        fetch_entry_t e, h;
        pop  = (q.size() != 0) && out_ready;
        push = in_valid && q.size() != DEPTH && !flush;
        if (flush) begin
            if (flush_keep && q.size() != 0) begin
                h = q[0];
                q.delete();
                if (!pop) q.push_back(h);
            end else begin
                q.delete();
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.inst = (in_exc != 2'b00) ? 32'h0 : in_inst;
                e.pc   = in_pc;
                e.exc  = in_exc;
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        #2;
        check_model();
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [1:0] exc,
                         input bit rdy, input bit fl, input bit keep);
        in_valid   = v;
        in_pc      = pc;
        in_inst    = $urandom;
        in_exc     = exc;
        out_ready  = rdy;
        flush      = fl;
        flush_keep = keep;
    endtask

    initial begin
        logic [31:0] head_pc;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;

        // Fill to full with ID stalled
        for (int i = 0; i < 4; i++) begin
            drive(1, RESET_PC + 32'(4 * i), 2'b00, 0, 0, 0);
            cycle();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        drive(1, RESET_PC + 32'h10, 2'b00, 0, 0, 0);
        cycle();
        chk("refused_count", 64'(count), 64'd4);
        chk("refused_head", 64'(out_pc), 64'(RESET_PC));

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 2'b00, 1, 0, 0);
            #1;
            chk("drain_pc", 64'(out_pc), 64'(RESET_PC + 32'(4 * i)));
            cycle();
        end
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk("drained_pc", 64'(out_pc), 64'd0);
        chk("drained_inst", 64'(out_inst), 64'd0);

        // Full queue with simultaneous pop and push attempt
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + 32'(4 * i), 2'b00, 0, 0, 0);
            cycle();
        end
        drive(1, 32'h2000, 2'b00, 1, 0, 0);
        #1;
        chk("fullpop_ready", 64'(in_ready), 64'd0);
        cycle();
        chk("fullpop_count", 64'(count), 64'd3);

        // Flush keeping the delay-slot head
        head_pc = out_pc;
        chk("keep_head_pre", 64'(head_pc), 64'h1004);
        drive(0, 0, 2'b00, 0, 1, 1);
        cycle();
        chk("keep_count", 64'(count), 64'd1);
        chk("keep_head", 64'(out_pc), 64'(head_pc));
        drive(1, 32'h3000, 2'b00, 0, 0, 0);
        cycle();
        drive(0, 0, 2'b00, 1, 0, 0);
        #1;
        chk("keep_order0", 64'(out_pc), 64'h1004);
        cycle();
        chk("keep_order1", 64'(out_pc), 64'h3000);
        cycle();

        // Exception entry becomes a NOP
        drive(1, 32'h4000, 2'b10, 0, 0, 0);
        in_inst = 32'h8c01_0004;
        cycle();
        chk("exc_inst", 64'(out_inst), 64'd0);
        chk("exc_code", 64'(out_exc), 64'd2);
        chk("exc_pc", 64'(out_pc), 64'h4000);
        drive(1, 32'h5000, 2'b00, 0, 1, 0);
        cycle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h6000 + 32'(4 * i), 2'b00, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 2'b00, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_pc", 64'(out_pc), 64'd0);
        q.delete();
        @(negedge clk);
        #1;
        reset = 1'b1;
        drive(1, 32'h7000, 2'b00, 0, 0, 0);
        cycle();
        chk("arst_first", 64'(out_pc), 64'h7000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom & 32'hffff_fffc,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
